pipe_mult_param: RTL and testbench
==================================

# pipe_mult_param

Parametrised, fully pipelined integer multiplier. It computes the full 2*WIDTH product of two WIDTH-bit operands, processing BITS_PER_STAGE multiplier bits per stage. Each operation selects signed or unsigned mode and which product half to return, and carries a tag through the pipe. A valid/ready handshake with global stall, plus a synchronous flush, lets the ALU/issue logic stream one operation per cycle and squash in-flight work on mispredict.

## Interface
- WIDTH, 64, operand width; must be a multiple of BITS_PER_STAGE.
- BITS_PER_STAGE, 8, multiplier bits consumed per stage; STAGES = WIDTH/BITS_PER_STAGE.
- TAG_W, 6, width of opaque tag carried with each operation.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  block accepts an operation this cycle.
- mcand  in  WIDTH  multiplicand.
- mplier  in  WIDTH  multiplier.
- is_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- want_high  in  1  1 = return product[2*WIDTH-1:WIDTH]; 0 = return product[WIDTH-1:0].
- tag_in  in  TAG_W  carried unchanged to tag_out.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  selected product half.
- tag_out  out  TAG_W  tag of the operation on result.

## Operation
- Accept: an operation is accepted when in_valid && in_ready.
- Input register:
  - Stores operand magnitudes: absolute values if is_signed, raw values otherwise.
  - Stores negate = is_signed && (mcand[WIDTH-1] ^ mplier[WIDTH-1]).
  - Stores want_high and the tag.
  - Magnitudes are held as WIDTH+1 bits so that |most-negative| is exact.
- Stages 0..STAGES-1, each registered. Stage k:
  - Adds (mplier_slice * mcand_shifted) into a 2*WIDTH accumulator.
  - Shifts the multiplier right and the multiplicand left by BITS_PER_STAGE for the next stage.
  - All arithmetic is modulo 2^(2*WIDTH).
- Output register:
  - Applies two's-complement negation of the accumulator if negate is set.
  - Selects the half given by want_high and asserts out_valid.
- Stall:
  - stall = out_valid && !out_ready.
  - While stall is high, every pipeline register, including its valid bit, holds its value, and in_ready = 0.
  - Otherwise in_ready = 1, and every stage advances each cycle, including bubbles.
- Flush: on a cycle with flush = 1:
  - All valid bits, including out_valid, clear at the next edge.
  - Any operation presented that cycle is not accepted; in_ready = 0 while flush = 1.
  - Flush overrides stall.
  - Data registers need not clear.
- Reset (reset_n low):
  - Asynchronously clears all valid bits, out_valid, result and tag_out to 0.
  - in_ready is 0 while reset_n is low and 1 at the first edge after release.
- Ordering: results are produced in strict acceptance order. There is no reordering and no dropping except by flush or reset.

## Timing
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+STAGES+1, with no stall. For defaults that is 9 cycles.
- Throughput: one operation per cycle when out_ready stays high.
- A stall of S cycles delays every in-flight result by exactly S cycles. No result is lost or duplicated.
- A result is held stable (result and tag_out unchanged) while out_valid && !out_ready.
- Assertion of reset_n low mid-operation discards all in-flight work. No out_valid pulse follows release until new operations are accepted.
- Boundary cases:
  - Unsigned: 0*x = 0.
  - Signed: most-negative * -1 returns 2^(WIDTH-1) with correct high half; the low half wraps.
  - Signed: most-negative squared gives high = 2^(WIDTH-2), low = 0.

## Test plan
- Unsigned max (WIDTH=64): mcand = mplier = 0xFFFF_FFFF_FFFF_FFFF, is_signed = 0.
  - want_high = 0 -> result 0x0000_0000_0000_0001, 9 cycles after accept.
  - want_high = 1 -> result 0xFFFF_FFFF_FFFF_FFFE.
- Signed: -3 * 5.
  - want_high = 0 -> result 0xFFFF_FFFF_FFFF_FFF1.
  - want_high = 1 -> result 0xFFFF_FFFF_FFFF_FFFF.
  - Signed 0x8000_0000_0000_0000 squared, want_high = 1 -> result 0x4000_0000_0000_0000.
- Stream with stall:
  - Stimulus: 20 back-to-back ops with tags 0..19 and random operands; hold out_ready = 0 for 3 cycles at cycle 12.
  - Required: all 20 results arrive in tag order, matching a reference model. in_ready = 0 exactly during the stall. Last result is 3 cycles later than it would be with no stall.
- Flush:
  - Stimulus: accept 5 ops, assert flush for 1 cycle with in_valid high.
  - Required: out_valid = 0 next cycle. No flushed tag ever appears; the op presented during flush is not accepted.
  - Next accepted op returns correctly 9 cycles later.
- Reset mid-operation: drive reset_n low for 1 cycle with 4 ops in flight.
  - Required: out_valid and result go 0 immediately, without waiting for a clock edge.
  - No stale result after release.
- Parameter variant: WIDTH=32, BITS_PER_STAGE=4 (latency 9), signed 0x7FFF_FFFF * 0x8000_0000.
  - want_high = 0 -> result 0x8000_0000.
  - want_high = 1 -> result 0xC000_0000.

Source files
------------

// File: rtl/pipe_mult_param.sv
// rtl/pipe_mult_param.sv - pipelined signed/unsigned multiplier consuming BITS_PER_STAGE multiplier bits per stage
module pipe_mult_param #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_STAGE = 8,
    parameter int TAG_W          = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    input  logic             is_signed,
    input  logic             want_high,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out
);
    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;
    localparam int MW     = WIDTH + 1;
    localparam int SW     = BITS_PER_STAGE + 1;

    logic             ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [TAG_W-1:0] tag_out_q;

    logic stall;
    logic advance;
    logic accept;

    logic [MW-1:0] mcand_ext;
    logic [MW-1:0] mplier_ext;
    logic [MW-1:0] mcand_mag_d;
    logic [MW-1:0] mplier_mag_d;
    logic          negate_d;

    // Index 0 is the input register; index k+1 holds the state after stage k.
    logic             valid_q  [0:STAGES];
    logic             neg_q    [0:STAGES];
    logic             high_q   [0:STAGES];
    logic [TAG_W-1:0] tag_q    [0:STAGES];
    logic [PW-1:0]    mcand_q  [0:STAGES-1];
    logic [MW-1:0]    mplier_q [0:STAGES-1];
    logic [PW-1:0]    acc_q    [1:STAGES];
    logic [PW-1:0]    sum_d    [0:STAGES-1];
    logic [PW-1:0]    prod_d;

    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = ready_q && !stall && !flush;
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_out_q;

    // One extra magnitude bit keeps |most-negative| exact.
    assign mcand_ext    = {is_signed & mcand[WIDTH-1], mcand};
    assign mplier_ext   = {is_signed & mplier[WIDTH-1], mplier};
    assign mcand_mag_d  = mcand_ext[WIDTH] ? -mcand_ext : mcand_ext;
    assign mplier_mag_d = mplier_ext[WIDTH] ? -mplier_ext : mplier_ext;
    assign negate_d     = is_signed & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] slice_d;
        // The last stage also takes the magnitude's top bit (weight 2^WIDTH).
        if (k == STAGES - 1) begin : g_last
            assign slice_d = mplier_q[k][SW-1:0];
        end else begin : g_mid
            assign slice_d = {1'b0, mplier_q[k][BITS_PER_STAGE-1:0]};
        end
        if (k == 0) begin : g_first
            assign sum_d[k] = PW'(slice_d) * mcand_q[k];
        end else begin : g_rest
            assign sum_d[k] = acc_q[k] + PW'(slice_d) * mcand_q[k];
        end
    end

    assign prod_d   = neg_q[STAGES] ? -acc_q[STAGES] : acc_q[STAGES];
    assign result_d = high_q[STAGES] ? prod_d[PW-1:WIDTH] : prod_d[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            tag_out_q   <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                valid_q[k] <= 1'b0;
                neg_q[k]   <= 1'b0;
                high_q[k]  <= 1'b0;
                tag_q[k]   <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
                acc_q[k+1]  <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (flush) begin
                out_valid_q <= 1'b0;
                for (int k = 0; k <= STAGES; k++) begin
                    valid_q[k] <= 1'b0;
                end
            end else if (advance) begin
                valid_q[0]  <= accept;
                neg_q[0]    <= negate_d;
                high_q[0]   <= want_high;
                tag_q[0]    <= tag_in;
                mcand_q[0]  <= PW'(mcand_mag_d);
                mplier_q[0] <= mplier_mag_d;
                for (int k = 1; k <= STAGES; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    neg_q[k]   <= neg_q[k-1];
                    high_q[k]  <= high_q[k-1];
                    tag_q[k]   <= tag_q[k-1];
                    acc_q[k]   <= sum_d[k-1];
                end
                for (int k = 1; k < STAGES; k++) begin
                    mcand_q[k]  <= mcand_q[k-1] << BITS_PER_STAGE;
                    mplier_q[k] <= mplier_q[k-1] >> BITS_PER_STAGE;
                end
                out_valid_q <= valid_q[STAGES];
                result_q    <= result_d;
                tag_out_q   <= tag_q[STAGES];
            end
        end
    end
endmodule

// File: tb/tb_pipe_mult_param.sv
// tb/tb_pipe_mult_param.sv - randomized scoreboard bench for pipe_mult_param
module tb_pipe_mult_param;
    localparam int W   = 64;
    localparam int TW  = 6;
    localparam int LAT = 9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  mcand = '0;
    logic [W-1:0]  mplier = '0;
    logic          is_signed = 1'b0;
    logic          want_high = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [TW-1:0] tag_out;

    logic          s_in_valid = 1'b0;
    logic          s_in_ready;
    logic [31:0]   s_mcand = '0;
    logic [31:0]   s_mplier = '0;
    logic          s_signed = 1'b0;
    logic          s_high = 1'b0;
    logic [TW-1:0] s_tag = '0;
    logic          s_flush = 1'b0;
    logic          s_out_valid;
    logic          s_out_ready = 1'b1;
    logic [31:0]   s_result;
    logic [TW-1:0] s_tag_out;

    always #5 clock = ~clock;

    pipe_mult_param u_dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mcand(mcand), .mplier(mplier), .is_signed(is_signed), .want_high(want_high),
        .tag_in(tag_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out)
    );

    pipe_mult_param #(.WIDTH(32), .BITS_PER_STAGE(4), .TAG_W(TW)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .mcand(s_mcand), .mplier(s_mplier), .is_signed(s_signed), .want_high(s_high),
        .tag_in(s_tag), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .tag_out(s_tag_out)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        int            edge_n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_acc_edge = 0;
    int   last_out_cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s, input logic h);
        logic [2*W-1:0] ea, eb, p;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ea * eb;
        return h ? p[2*W-1:W] : p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 64'h8000_0000_0000_0000;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h0;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && in_valid && in_ready) begin
            e.res    = ref_mult(mcand, mplier, is_signed, want_high);
            e.tag    = tag_in;
            e.edge_n = cyc + 1;
            sb.push_back(e);
            last_acc_edge = cyc + 1;
        end
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {58'b0, tag_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("tag", {58'b0, tag_out}, {58'b0, e.tag});
                last_out_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic h, input logic [TW-1:0] t);
        int  k;
        logic ok;
        in_valid = 1'b1; mcand = a; mplier = b; is_signed = s; want_high = h; tag_in = t;
        k = 0;
        do begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            k++;
        end while (!ok && k < 100);
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clock);
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic h, input logic [TW-1:0] t,
                            input logic [W-1:0] exp);
        int k;
        drain();
        send(a, b, s, h, t);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!out_valid && k < 40);
        check(name, result, exp);
        check({name, "_tag"}, {58'b0, tag_out}, {58'b0, t});
        check({name, "_lat"}, 64'(cyc - last_acc_edge), 64'(LAT));
        @(posedge clock);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic h, input logic [31:0] exp);
        int k, acc_edge;
        s_in_valid = 1'b1; s_mcand = a; s_mplier = b; s_signed = 1'b1; s_high = h; s_tag = 6'd33;
        @(negedge clock);
        check({name, "_ready"}, {63'b0, s_in_ready}, 64'd1);
        acc_edge = cyc + 1;
        @(posedge clock);
        #1;
        s_in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!s_out_valid && k < 40);
        check(name, {32'b0, s_result}, {32'b0, exp});
        check({name, "_lat"}, 64'(cyc - acc_edge), 64'(LAT));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   first_acc;
        int   k;
        logic done;
        logic [W-1:0] held;

        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_tag_out", {58'b0, tag_out}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_before_edge", {63'b0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        check("ready_after_edge", {63'b0, in_ready}, 64'd1);

        directed("umax_lo", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 6'd1, 64'h0000_0000_0000_0001);
        directed("umax_hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE + 64'd1, 1'b0, 1'b1, 6'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        directed("neg3x5_lo", -64'sd3, 64'd5, 1'b1, 1'b0, 6'd3, 64'hFFFF_FFFF_FFFF_FFF1);
        directed("neg3x5_hi", -64'sd3, 64'd5, 1'b1, 1'b1, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        directed("minsq_hi", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 6'd5, 64'h4000_0000_0000_0000);
        directed("minsq_lo", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 6'd6, 64'h0);
        directed("minxm1_lo", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 6'd7, 64'h8000_0000_0000_0000);
        directed("minxm1_hi", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 6'd8, 64'h0);
        directed("zero_u", 64'h0, 64'hDEAD_BEEF_1234_5678, 1'b0, 1'b1, 6'd9, 64'h0);

        drain();
        first_acc = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'(i));
                    if (i == 0) first_acc = last_acc_edge;
                end
            end
            begin
                repeat (11) @(posedge clock);
                @(negedge clock);
                check("pre_stall_ready", {63'b0, in_ready}, 64'd1);
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                held = '0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check("stall_ready", {63'b0, in_ready}, 64'd0);
                    check("stall_valid", {63'b0, out_valid}, 64'd1);
                    if (j == 0) held = result;
                    else check("stall_hold", result, held);
                    @(posedge clock);
                end
                #1;
                out_ready = 1'b1;
                @(negedge clock);
                check("post_stall_ready", {63'b0, in_ready}, 64'd1);
            end
        join
        drain();
        check("stall_last_delay", 64'(last_out_cyc - first_acc), 64'(19 + LAT + 3));

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'(i + 20));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(rand_op(), rand_op(), 1'b1, 1'b0, 6'(40 + i));
        k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clock);
            k++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b1; tag_in = 6'd45; mcand = 64'd7; mplier = 64'd9; flush = 1'b1;
        @(negedge clock);
        check("flush_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        @(negedge clock);
        check("flush_out_valid", {63'b0, out_valid}, 64'd0);
        repeat (15) @(posedge clock);
        #1;
        directed("after_flush", 64'd123456789, -64'sd1000, 1'b1, 1'b0, 6'd46, -64'sd123456789000);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_op(), rand_op(), 1'b0, 1'b1, 6'(50 + i));
        k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clock);
            k++;
        end
        check("pre_reset_valid", {63'b0, out_valid}, 64'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", {63'b0, out_valid}, 64'd0);
        check("async_result", result, 64'd0);
        check("async_tag_out", {58'b0, tag_out}, 64'd0);
        check("async_in_ready", {63'b0, in_ready}, 64'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("rel_ready_0", {63'b0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        check("rel_ready_1", {63'b0, in_ready}, 64'd1);
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("no_stale", {63'b0, out_valid}, 64'd0);
        @(posedge clock);
        #1;
        directed("after_reset", 64'd3, 64'd5, 1'b0, 1'b0, 6'd55, 64'd15);

        check32("w32_lo", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h8000_0000);
        check32("w32_hi", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'hC000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
